// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the bit-serial magnitude comparator.
package serial_cmp_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operand width used when an instance does not override it.
    localparam int DEFAULT_WIDTH = 8;

    // Bit index register width. A 1-bit operand still needs a 1-bit index.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_compare_ctrl_if.sv
// Request/result bundle between a comparison requester and the serial comparator.
interface serial_compare_ctrl_if
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    // Requester side: issues operands and start, observes status and result.
    modport master (
        output start, a, b,
        input  busy, done, eq, gt, lt
    );

    // Comparator side.
    modport slave (
        input  start, a, b,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/bit_compare_cell.sv
// Cascaded 1-bit magnitude compare cell. Once a higher bit has decided the
// outcome (eq_in low), the incoming gt/lt verdict passes through unchanged.
module bit_compare_cell (
    input  logic eq_in,
    input  logic gt_in,
    input  logic lt_in,
    input  logic a,
    input  logic b,
    output logic eq,
    output logic gt,
    output logic lt
);
    assign eq = eq_in & ~(a ^ b);
    assign gt = eq_in ? (a & ~b) : gt_in;
    assign lt = eq_in ? (~a & b) : lt_in;
endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator controller: latches two operands on start,
// walks them MSB-first through one compare cell, and stops at the first
// differing bit. Result flags are registered and valid while done is high.
module serial_compare_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    serial_compare_ctrl_if.slave bus
);
    localparam int              IDXW    = idx_width(WIDTH);
    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [IDXW-1:0]  idx_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic             a_bit;
    logic             b_bit;
    logic             cell_eq;
    logic             cell_gt;
    logic             cell_lt;
    logic             load;
    logic             step;
    logic             last_step;

    // A 1-bit operand has only bit 0; avoid selecting with a wider index.
    generate
        if (WIDTH == 1) begin : g_single_bit
            assign a_bit = a_sh[0];
            assign b_bit = b_sh[0];
        end else begin : g_multi_bit
            assign a_bit = a_sh[idx_q];
            assign b_bit = b_sh[idx_q];
        end
    endgenerate

    bit_compare_cell u_cell (
        .eq_in (eq_q),
        .gt_in (gt_q),
        .lt_in (lt_q),
        .a     (a_bit),
        .b     (b_bit),
        .eq    (cell_eq),
        .gt    (cell_gt),
        .lt    (cell_lt)
    );

    // The walk ends on the LSB or as soon as the bits have differed.
    assign last_step = (idx_q == '0) || !cell_eq;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_step) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, index walk and result registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are few and reset too, so an aborted run leaves no stale result.
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            idx_q <= '0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else if (load) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            idx_q <= IDX_MSB;
            eq_q  <= 1'b1;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else if (step) begin
            eq_q <= cell_eq;
            gt_q <= cell_gt;
            lt_q <= cell_lt;
            if (!last_step) idx_q <= idx_q - 1'b1;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl: an 8-bit and a 1-bit instance,
// with expected results queued at launch and popped when done appears.
module tb_serial_compare_ctrl;

    typedef struct {
        logic  eq;
        logic  gt;
        logic  lt;
        int    lat;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb8[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    serial_compare_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_compare_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_compare_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_compare_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // Reference: unsigned compare, and step count from the first differing bit.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input string tag);
        exp_t e;
        int   k;
        k = w;
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                k = w - i;
                break;
            end
        end
        e.eq  = (a == b);
        e.gt  = (a > b);
        e.lt  = (a < b);
        e.lat = k + 1;
        e.tag = tag;
        return e;
    endfunction

    // Present a request for one edge; returns 1 time unit after the accepting edge.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input string tag);
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.a = a; bus8.b = b;
        sb8.push_back(model(8, {24'd0, a}, {24'd0, b}, tag));
        @(posedge clk); #1;
        bus8.start = 1'b0;
    endtask

    task automatic launch1(input logic a, input logic b, input string tag);
        @(posedge clk); #1;
        bus1.start = 1'b1; bus1.a = a; bus1.b = b;
        sb1.push_back(model(1, {31'd0, a}, {31'd0, b}, tag));
        @(posedge clk); #1;
        bus1.start = 1'b0;
    endtask

    // Count edges from acceptance to done (acceptance edge counts as 1), bounded.
    task automatic wait8(output int lat, output int busy_cyc, output bit timed_out);
        lat = 1; busy_cyc = 0; timed_out = 1'b0;
        while (!bus8.done) begin
            if (bus8.busy) busy_cyc++;
            if (lat > 40) begin timed_out = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait1(output int lat, output bit timed_out);
        lat = 1; timed_out = 1'b0;
        while (!bus1.done) begin
            if (lat > 40) begin timed_out = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        #12;
        n_cmp++;
        if ({bus8.busy, bus8.done, bus8.eq, bus8.gt, bus8.lt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset8 busy/done/eq/gt/lt=%b expected 00000",
                     {bus8.busy, bus8.done, bus8.eq, bus8.gt, bus8.lt});
        end
        n_cmp++;
        if ({bus1.busy, bus1.done, bus1.eq, bus1.gt, bus1.lt} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset1 busy/done/eq/gt/lt=%b expected 00000",
                     {bus1.busy, bus1.done, bus1.eq, bus1.gt, bus1.lt});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fixed boundary patterns followed by random operand pairs.
    task automatic test_patterns();
        logic [7:0] pa[3] = '{8'hA5, 8'h80, 8'h12};
        logic [7:0] pb[3] = '{8'hA5, 8'h7F, 8'h13};
        exp_t e;
        int   lat, busy_cyc;
        bit   to;
        for (int i = 0; i < 11; i++) begin
            logic [7:0] a, b;
            if (i < 3) begin
                a = pa[i]; b = pb[i];
            end else begin
                a = 8'($urandom_range(0, 255));
                b = (i % 3 == 0) ? a : 8'($urandom_range(0, 255));
            end
            launch8(a, b, $sformatf("pat%0d_%02h_%02h", i, a, b));
            wait8(lat, busy_cyc, to);
            e = sb8.pop_front();
            n_cmp++;
            if (to) begin
                n_fail++;
                $display("FAIL %s done never seen within 40 edges", e.tag);
                continue;
            end
            if ({bus8.eq, bus8.gt, bus8.lt} !== {e.eq, e.gt, e.lt}) begin
                n_fail++;
                $display("FAIL %s eq/gt/lt=%b expected %b", e.tag,
                         {bus8.eq, bus8.gt, bus8.lt}, {e.eq, e.gt, e.lt});
            end
            n_cmp++;
            if (lat != e.lat) begin
                n_fail++;
                $display("FAIL %s latency=%0d expected %0d", e.tag, lat, e.lat);
            end
            n_cmp++;
            if (busy_cyc != e.lat - 1) begin
                n_fail++;
                $display("FAIL %s busy cycles=%0d expected %0d", e.tag, busy_cyc, e.lat - 1);
            end
            @(posedge clk); #1;
            n_cmp++;
            if ({bus8.done, bus8.busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s done/busy after pulse=%b expected 00", e.tag,
                         {bus8.done, bus8.busy});
            end
        end
    endtask

    // start held high through RUN and DONE must not queue a second comparison.
    task automatic test_ignored_start();
        exp_t e;
        int   lat, busy_cyc, pulses;
        bit   to;
        launch8(8'h80, 8'h7F, "ignored_start");
        bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'hFF;
        wait8(lat, busy_cyc, to);
        e = sb8.pop_front();
        n_cmp++;
        if (to || lat != 2) begin
            n_fail++;
            $display("FAIL ignored_start latency=%0d timeout=%0d expected 2", lat, to);
        end
        @(posedge clk); #1;
        bus8.start = 1'b0;
        n_cmp++;
        if (bus8.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_done_cycle busy=%b expected 0", bus8.busy);
        end
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus8.done) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL ignored_start extra done pulses=%0d expected 0", pulses);
        end
        n_cmp++;
        if ({bus8.eq, bus8.gt, bus8.lt} !== {e.eq, e.gt, e.lt}) begin
            n_fail++;
            $display("FAIL ignored_start result eq/gt/lt=%b expected %b",
                     {bus8.eq, bus8.gt, bus8.lt}, {e.eq, e.gt, e.lt});
        end
    endtask

    // Asynchronous reset mid-run aborts without a done pulse.
    task automatic test_async_reset();
        exp_t e;
        int   lat, busy_cyc, pulses;
        bit   to;
        launch8(8'h01, 8'h01, "aborted");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        void'(sb8.pop_back());
        n_cmp++;
        if ({bus8.busy, bus8.done, bus8.eq, bus8.gt, bus8.lt} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset busy/done/eq/gt/lt=%b expected 00000",
                     {bus8.busy, bus8.done, bus8.eq, bus8.gt, bus8.lt});
        end
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus8.done) pulses++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus8.done) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL async_reset done pulses=%0d expected 0", pulses);
        end
        launch8(8'h01, 8'h01, "after_reset");
        wait8(lat, busy_cyc, to);
        e = sb8.pop_front();
        n_cmp++;
        if (to || {bus8.eq, bus8.gt, bus8.lt} !== {e.eq, e.gt, e.lt} || lat != e.lat) begin
            n_fail++;
            $display("FAIL after_reset eq/gt/lt=%b lat=%0d timeout=%0d expected %b lat=%0d",
                     {bus8.eq, bus8.gt, bus8.lt}, lat, to, {e.eq, e.gt, e.lt}, e.lat);
        end
        @(posedge clk); #1;
    endtask

    // 1-bit instance, then a back-to-back request issued during the DONE cycle.
    task automatic test_width1();
        logic pa[3] = '{1'b1, 1'b0, 1'b0};
        logic pb[3] = '{1'b0, 1'b0, 1'b1};
        exp_t e;
        int   lat;
        bit   to;
        for (int i = 0; i < 2; i++) begin
            launch1(pa[i], pb[i], $sformatf("w1_%0d%0d", pa[i], pb[i]));
            wait1(lat, to);
            e = sb1.pop_front();
            n_cmp++;
            if (to || {bus1.eq, bus1.gt, bus1.lt} !== {e.eq, e.gt, e.lt} || lat != 2) begin
                n_fail++;
                $display("FAIL %s eq/gt/lt=%b lat=%0d timeout=%0d expected %b lat=2",
                         e.tag, {bus1.eq, bus1.gt, bus1.lt}, lat, to, {e.eq, e.gt, e.lt});
            end
        end
        bus1.start = 1'b1; bus1.a = pa[2]; bus1.b = pb[2];
        sb1.push_back(model(1, {31'd0, pa[2]}, {31'd0, pb[2]}, "w1_b2b"));
        @(posedge clk); #1;
        n_cmp++;
        if (bus1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_b2b start during DONE busy=%b expected 0", bus1.busy);
        end
        @(posedge clk); #1;
        bus1.start = 1'b0;
        n_cmp++;
        if (bus1.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_b2b first IDLE edge busy=%b expected 1", bus1.busy);
        end
        wait1(lat, to);
        e = sb1.pop_front();
        n_cmp++;
        if (to || {bus1.eq, bus1.gt, bus1.lt} !== {e.eq, e.gt, e.lt} || lat != e.lat) begin
            n_fail++;
            $display("FAIL %s eq/gt/lt=%b lat=%0d timeout=%0d expected %b lat=%0d",
                     e.tag, {bus1.eq, bus1.gt, bus1.lt}, lat, to, {e.eq, e.gt, e.lt}, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_ignored_start();
        test_async_reset();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
